// File: rtl/stream_acc_pkg.sv
// Shared types and defaults for the stream accumulator.
// Build option: STREAM_ACC_SAT_EN selects saturating accumulation.
package stream_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_WINDOW = 4;

  function automatic int cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Accumulator adder with carry out of ACC_W.
// Build option: STREAM_ACC_SAT_EN clamps the sum to all-ones on carry.
module acc_sat_add #(
  parameter int ACC_W  = 32,
  parameter int DATA_W = 32
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  localparam int W = ((ACC_W > DATA_W) ? ACC_W : DATA_W) + 1;

  logic [W-1:0] full;

  assign full  = W'(a) + W'(b);
  assign carry = |full[W-1:ACC_W];

`ifdef STREAM_ACC_SAT_EN
  assign sum = carry ? '1 : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/stream_accumulator.sv
// Windowed accumulator for the adder result stream.
// Build option: STREAM_ACC_SAT_EN saturates instead of wrapping.
module stream_accumulator
  import stream_acc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int WINDOW = DEF_WINDOW,
  parameter int CNT_W  = cnt_w(WINDOW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              overflow
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   sum;
  logic               carry;
  logic               accept;
  logic               last;

  acc_sat_add #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_add (
    .a     (acc_q),
    .b     (in_data),
    .sum   (sum),
    .carry (carry)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign overflow  = ovf_q;

  assign accept = in_valid & in_ready;
  assign last   = (cnt_q == CNT_W'(WINDOW - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_q | carry;
        end
        // flush closes a window only if it holds at least one sample
        if ((accept && last) ||
            (flush && (accept || cnt_q != '0)))
          state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_stream_accumulator.sv
// Bench for stream_accumulator (WINDOW=4), table vectors plus
// hand sequences, checked through an expected-result queue.
module tb_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        overflow;

  always #5 clk = ~clk;

  stream_accumulator #(
    .DATA_W (32),
    .ACC_W  (32),
    .WINDOW (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .overflow  (overflow)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  cnt;
    logic        ovf;
  } exp_t;

  typedef struct {
    int          n;
    logic [31:0] d [4];
    logic        fl;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  logic m_live = 1'b0;
  logic m_hold = 1'b0;
  logic m_rst_chk = 1'b0;
  int   m_cnt = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // checker + handshake model; inputs seen here land on the next posedge
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("in_ready", 32'(in_ready), 32'(!m_hold));
      chk("out_valid", 32'(out_valid), 32'(m_hold));
      if (m_rst_chk) begin
        chk("rst_data", out_data, 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        m_rst_chk = 1'b0;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h expected none", out_data);
        end else begin
          chk("out_data", out_data, q[0].data);
          chk("out_count", 32'(out_count), 32'(q[0].cnt));
          chk("overflow", 32'(overflow), 32'(q[0].ovf));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
    if (rst) begin
      m_hold    = 1'b0;
      m_cnt     = 0;
      m_live    = 1'b1;
      m_rst_chk = 1'b1;
      q.delete();
    end else if (!m_hold) begin
      if (in_valid) m_cnt++;
      if (m_cnt == 4 || (flush && m_cnt > 0)) m_hold = 1'b1;
    end else if (out_ready) begin
      m_hold = 1'b0;
      m_cnt  = 0;
    end
  end

  task automatic push(input logic [31:0] d,
                      input logic [2:0] c,
                      input logic o);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    e.ovf  = o;
    q.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input logic f);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    flush    = f;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t        vt [6];
  logic [31:0] rd [4];
  logic [31:0] rsum;

  initial begin
    vt[0] = '{4, '{32'd1, 32'd2, 32'd3, 32'd4}, 1'b0, 32'd10, 3'd4, 1'b0};
    vt[1] = '{2, '{32'd5, 32'd7, 32'd0, 32'd0}, 1'b1, 32'd12, 3'd2, 1'b0};
`ifdef STREAM_ACC_SAT_EN
    vt[2] = '{4, '{32'hFFFFFFFF, 32'd2, 32'd0, 32'd0}, 1'b0,
              32'hFFFFFFFF, 3'd4, 1'b1};
`else
    vt[2] = '{4, '{32'hFFFFFFFF, 32'd2, 32'd0, 32'd0}, 1'b0,
              32'd1, 3'd4, 1'b1};
`endif
    vt[3] = '{4, '{32'd10, 32'd20, 32'd30, 32'd40}, 1'b0, 32'd100, 3'd4, 1'b0};
    vt[4] = '{1, '{32'h80000000, 32'd0, 32'd0, 32'd0}, 1'b1,
              32'h80000000, 3'd1, 1'b0};
    vt[5] = '{3, '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd2, 32'd0}, 1'b1,
              32'd0, 3'd3, 1'b1};
`ifdef STREAM_ACC_SAT_EN
    vt[5].e_data = 32'hFFFFFFFF;
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      push(vt[i].e_data, vt[i].e_cnt, vt[i].e_ovf);
      for (int j = 0; j < vt[i].n; j++)
        send(vt[i].d[j], vt[i].fl && (j == vt[i].n - 1));
      wait_idle();
    end

    // stalled output: held result, incoming samples refused
    out_ready = 1'b0;
    push(32'd10, 3'd4, 1'b0);
    for (int j = 1; j <= 4; j++) send(32'(j), 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd99;
    repeat (5) begin
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // flush with an empty window produces nothing
    flush = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    flush = 1'b0;

    // reset mid-window, then reset while holding a result
    push(32'd3, 3'd2, 1'b0);
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    pulse_rst();
    out_ready = 1'b0;
    push(32'd12, 3'd4, 1'b0);
    for (int j = 0; j < 4; j++) send(32'd3, 1'b0);
    @(posedge clk); #1;
    pulse_rst();
    out_ready = 1'b1;
    push(32'd4, 3'd4, 1'b0);
    for (int j = 0; j < 4; j++) send(32'd1, 1'b0);
    wait_idle();

    // gapped input stream against a reference sum
    for (int w = 0; w < 3; w++) begin
      rsum = '0;
      for (int j = 0; j < 4; j++) begin
        rd[j] = 32'($urandom_range(0, 1000000));
        rsum  = rsum + rd[j];
      end
      push(rsum, 3'd4, 1'b0);
      for (int j = 0; j < 4; j++) begin
        send(rd[j], 1'b0);
        repeat (w + 1) begin
          @(posedge clk); #1;
        end
      end
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
